// File: rtl/ahb_slave_responder_if.sv
// AHB bus bundle between an AHB master (driver) and the ahb_slave_responder target.
interface ahb_slave_responder_if;
  logic        HSELAHB;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSELAHB, HADDR, HTRANS, HWRITE, HWDATA,
    input  HREADY, HRESP, HRDATA
  );

  modport slave (
    input  HSELAHB, HADDR, HTRANS, HWRITE, HWDATA,
    output HREADY, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_slave_responder.sv
// AHB target backed by a word-addressed memory with programmable wait states
// and two-cycle ERROR responses for misaligned or out-of-window accesses.
// Optional feature macro: AHB_SLV_RO_REGION_EN -- when defined, writes to the
// first RO_WORDS words are answered with ERROR and leave memory unchanged.
module ahb_slave_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 0,
  parameter int          RO_WORDS    = 16
) (
  input  logic                 clk,
  input  logic                 HRESETn,
  ahb_slave_responder_if.slave ahb
);

  localparam int AW = $clog2(DEPTH);

`ifdef AHB_SLV_RO_REGION_EN
  localparam bit RO_EN = 1'b1;
`else
  localparam bit RO_EN = 1'b0;
`endif

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  localparam logic [31:0] WINDOW_BYTES = 32'(4 * DEPTH);
  localparam logic [3:0]  WAIT_LAST    = 4'(WAIT_STATES);

  logic [31:0]   mem [DEPTH];

  logic [2:0]    state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          write_q, write_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [32:0]   diff;
  logic [AW-1:0] req_idx;
  logic          req_err;
  logic          bus_ready;
  logic          accept;
  logic          commit_we;
  logic          load_rd;

  // Decode the address phase: window offset, word index, error decision and acceptance.
  always_comb begin
    diff      = {1'b0, ahb.HADDR} - {1'b0, BASE_ADDR};
    req_idx   = diff[AW+1:2];
    req_err   = (ahb.HADDR[1:0] != 2'b00) || diff[32] || (diff[31:0] >= WINDOW_BYTES);
    if (RO_EN && ahb.HWRITE && (int'(req_idx) < RO_WORDS)) begin
      req_err = 1'b1;
    end
    bus_ready = (state_q != ST_WAIT) && (state_q != ST_ERR1);
    accept    = ahb.HSELAHB && bus_ready &&
                ((ahb.HTRANS == 2'b10) || (ahb.HTRANS == 2'b11));
    commit_we = (state_q == ST_DATA) && write_q;
  end

  // Next-state logic: wait counting, transfer capture and read-data loading with write bypass.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    idx_d      = idx_q;
    write_d    = write_q;
    rdata_d    = rdata_q;
    load_rd    = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d    = ST_DATA;
          wait_cnt_d = 4'd0;
          load_rd    = !write_q;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
        write_d = 1'b0;
        if (accept) begin
          idx_d   = req_idx;
          write_d = ahb.HWRITE;
          if (req_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = 4'd1;
          end else begin
            state_d = ST_DATA;
            load_rd = !ahb.HWRITE;
          end
        end
      end
    endcase
    if (load_rd) begin
      rdata_d = (commit_we && (idx_q == idx_d)) ? ahb.HWDATA : mem[idx_d];
    end
  end

  // Control and read-data registers; reset drops any pending transfer immediately.
  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      idx_q      <= '0;
      write_q    <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      idx_q      <= idx_d;
      write_q    <= write_d;
      rdata_q    <= rdata_d;
    end
  end

  // Memory array is never reset; a write commits on the edge that ends its DATA phase.
  always_ff @(posedge clk) begin
    if (commit_we) begin
      mem[idx_q] <= ahb.HWDATA;
    end
  end

  assign ahb.HREADY = bus_ready;
  assign ahb.HRESP  = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? 2'b01 : 2'b00;
  assign ahb.HRDATA = rdata_q;

endmodule

// File: tb/tb_ahb_slave_responder.sv
// Randomized bench for ahb_slave_responder: two instances (zero and three wait
// states, different windows) checked against a sequential memory model.
module tb_ahb_slave_responder;

  localparam logic [31:0] BASE0  = 32'h0000_0000;
  localparam int          DEPTH0 = 256;
  localparam int          WS0    = 0;
  localparam logic [31:0] BASE1  = 32'h2000_0000;
  localparam int          DEPTH1 = 64;
  localparam int          WS1    = 3;
  localparam int          CYCLE_LIMIT = 4000;

`ifdef AHB_SLV_RO_REGION_EN
  localparam bit RO_EN = 1'b1;
`else
  localparam bit RO_EN = 1'b0;
`endif

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  op_t  ops[$];
  logic [31:0] mdl [2][256];
  bit          known [2][256];

  always #5 clk = ~clk;

  ahb_slave_responder_if bus0 ();
  ahb_slave_responder_if bus1 ();

  ahb_slave_responder #(.BASE_ADDR(BASE0), .DEPTH(DEPTH0), .WAIT_STATES(WS0), .RO_WORDS(16))
    dut0 (.clk(clk), .HRESETn(rst_n), .ahb(bus0));
  ahb_slave_responder #(.BASE_ADDR(BASE1), .DEPTH(DEPTH1), .WAIT_STATES(WS1), .RO_WORDS(16))
    dut1 (.clk(clk), .HRESETn(rst_n), .ahb(bus1));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] baseOf(input int w);
    return (w == 0) ? BASE0 : BASE1;
  endfunction

  function automatic int depthOf(input int w);
    return (w == 0) ? DEPTH0 : DEPTH1;
  endfunction

  function automatic int wsOf(input int w);
    return (w == 0) ? WS0 : WS1;
  endfunction

  function automatic int idxOf(input int w, input logic [31:0] a);
    logic [31:0] off;
    off = (a - baseOf(w)) >> 2;
    return int'(off) & (depthOf(w) - 1);
  endfunction

  function automatic bit expErr(input int w, input logic [31:0] a, input logic wr);
    longint la, lb, lim;
    bit     err;
    la  = {32'd0, a};
    lb  = {32'd0, baseOf(w)};
    lim = lb + 4 * depthOf(w);
    err = (a[1:0] != 2'b00) || (la < lb) || (la >= lim);
    if (RO_EN && !err && wr && (idxOf(w, a) < 16)) err = 1'b1;
    return err;
  endfunction

  function automatic logic [31:0] randAddr(input int w);
    int          sel;
    logic [31:0] b;
    b   = baseOf(w);
    sel = $urandom_range(0, 9);
    case (sel)
      0: return b + 32'(4 * depthOf(w));
      1: return b + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
      2: return (w == 1) ? b - 32'(4 * $urandom_range(1, 4))
                         : b + 32'(4 * depthOf(w)) + 32'(4 * $urandom_range(0, 255));
      3: return b + 32'(4 * (depthOf(w) - 1));
      default: return b + 32'(4 * $urandom_range(0, 15));
    endcase
  endfunction

  task automatic driveBus(input int w, input logic sel, input logic [1:0] trans,
                          input logic [31:0] addr, input logic wr);
    if (w == 0) begin
      bus0.HSELAHB = sel; bus0.HTRANS = trans; bus0.HADDR = addr; bus0.HWRITE = wr;
    end else begin
      bus1.HSELAHB = sel; bus1.HTRANS = trans; bus1.HADDR = addr; bus1.HWRITE = wr;
    end
  endtask

  task automatic setWdata(input int w, input logic [31:0] d);
    if (w == 0) bus0.HWDATA = d;
    else        bus1.HWDATA = d;
  endtask

  task automatic readBus(input int w, output logic r, output logic [1:0] p, output logic [31:0] d);
    if (w == 0) begin
      r = bus0.HREADY; p = bus0.HRESP; d = bus0.HRDATA;
    end else begin
      r = bus1.HREADY; p = bus1.HRESP; d = bus1.HRDATA;
    end
  endtask

  task automatic pushOp(input int kind, input logic [31:0] addr, input logic wr, input logic [31:0] data);
    op_t op;
    op.kind = kind; op.addr = addr; op.wr = wr; op.data = data;
    ops.push_back(op);
  endtask

  // Pipelined master: every negedge checks the data phase in flight, then
  // presents the next address phase (or junk while the target stalls).
  task automatic applyStimulus(input int w);
    int          i, n, lowCnt, cycles, idx;
    bit          dpValid, dpErr, dpWr;
    logic [31:0] dpAddr, dpData, d;
    logic        r;
    logic [1:0]  p;
    op_t         op;
    i = 0; n = ops.size(); lowCnt = 0; cycles = 0;
    dpValid = 1'b0; dpErr = 1'b0; dpWr = 1'b0; dpAddr = '0; dpData = '0;
    while ((i < n || dpValid) && cycles < CYCLE_LIMIT) begin
      @(negedge clk);
      cycles++;
      readBus(w, r, p, d);
      if (dpValid) begin
        checkOutput(dpErr ? "errResp" : "okResp", 32'(p), dpErr ? 32'd1 : 32'd0);
        if (!r) begin
          lowCnt++;
          if (lowCnt > 20) begin
            checkOutput("waitBound", 32'(lowCnt), dpErr ? 32'd1 : 32'(wsOf(w)));
            break;
          end
        end else begin
          checkOutput(dpErr ? "errWaits" : "okWaits", 32'(lowCnt), dpErr ? 32'd1 : 32'(wsOf(w)));
          idx = idxOf(w, dpAddr);
          if (!dpErr && dpWr) begin
            mdl[w][idx]   = dpData;
            known[w][idx] = 1'b1;
          end else if (!dpErr && known[w][idx]) begin
            checkOutput("readData", d, mdl[w][idx]);
          end
        end
      end else begin
        checkOutput("idleReady", 32'(r), 32'd1);
        checkOutput("idleResp", 32'(p), 32'd0);
      end
      setWdata(w, dpValid ? dpData : $urandom());
      if (r) begin
        dpValid = 1'b0;
        if (i < n) begin
          op = ops[i];
          i++;
          case (op.kind)
            0: begin
              driveBus(w, 1'b1, 2'b10, op.addr, op.wr);
              dpValid = 1'b1; dpErr = expErr(w, op.addr, op.wr);
              dpWr = op.wr; dpAddr = op.addr; dpData = op.data; lowCnt = 0;
            end
            1: driveBus(w, 1'b1, 2'b00, op.addr, 1'b1);
            2: driveBus(w, 1'b1, 2'b01, op.addr, 1'b1);
            default: driveBus(w, 1'b0, 2'b10, op.addr, op.wr);
          endcase
        end else begin
          driveBus(w, 1'b0, 2'b00, 32'd0, 1'b0);
        end
      end else begin
        driveBus(w, 1'b1, 2'b10, $urandom(), 1'b1);
      end
    end
    checkOutput("drained", {31'd0, (dpValid || (i < n))}, 32'd0);
    driveBus(w, 1'b0, 2'b00, 32'd0, 1'b0);
    ops.delete();
  endtask

  initial begin
    logic        r;
    logic [1:0]  p;
    logic [31:0] d;
    int          roll;

    driveBus(0, 1'b0, 2'b00, 32'd0, 1'b0);
    driveBus(1, 1'b0, 2'b00, 32'd0, 1'b0);
    setWdata(0, 32'd0);
    setWdata(1, 32'd0);
    repeat (2) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      readBus(w, r, p, d);
      checkOutput("rstReady", 32'(r), 32'd1);
      checkOutput("rstResp", 32'(p), 32'd0);
      checkOutput("rstRdata", d, 32'd0);
    end
    rst_n = 1'b1;

    // Zero-wait target: write/read, pipelined bypass, idle/busy/unselected, errors
    pushOp(0, 32'h40, 1'b1, 32'hDEAD_BEEF);
    pushOp(0, 32'h40, 1'b0, 32'd0);
    pushOp(1, 32'h40, 1'b1, 32'd0);
    pushOp(0, 32'h10, 1'b1, 32'h1111_2222);
    pushOp(0, 32'h10, 1'b0, 32'd0);
    pushOp(1, 32'h10, 1'b1, 32'd0);
    pushOp(2, 32'h10, 1'b1, 32'd0);
    pushOp(3, 32'h10, 1'b1, 32'hBAD0_BAD0);
    pushOp(0, 32'h10, 1'b0, 32'd0);
    pushOp(0, 32'h402, 1'b0, 32'd0);
    pushOp(0, 32'h400, 1'b0, 32'd0);
    pushOp(0, 32'h400, 1'b1, 32'h1234_5678);
    pushOp(0, 32'h40, 1'b0, 32'd0);
    applyStimulus(0);

    // Three-wait target: waited read, errors past end, misaligned and below base
    pushOp(0, BASE1 + 32'h80, 1'b1, 32'hCAFE_F00D);
    pushOp(1, BASE1, 1'b0, 32'd0);
    pushOp(0, BASE1 + 32'h80, 1'b0, 32'd0);
    pushOp(0, BASE1 + 32'h100, 1'b0, 32'd0);
    pushOp(0, BASE1 + 32'h42, 1'b0, 32'd0);
    pushOp(0, BASE1 - 32'h4, 1'b1, 32'h0BAD_0BAD);
    pushOp(0, BASE1 + 32'h40, 1'b1, 32'h0040_0040);
    pushOp(0, BASE1 + 32'h40, 1'b0, 32'd0);
    applyStimulus(1);

    if (RO_EN) begin
      pushOp(0, 32'h0C, 1'b1, 32'h0000_AAAA);
      pushOp(0, 32'h40, 1'b1, 32'h0000_1616);
      pushOp(0, 32'h40, 1'b0, 32'd0);
      applyStimulus(0);
    end

    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 150; k++) begin
        roll = $urandom_range(0, 9);
        if (roll < 7)       pushOp(0, randAddr(w), 1'($urandom_range(0, 1)), $urandom());
        else if (roll == 7) pushOp(1, randAddr(w), 1'b1, 32'd0);
        else if (roll == 8) pushOp(2, randAddr(w), 1'b1, 32'd0);
        else                pushOp(3, randAddr(w), 1'b1, $urandom());
      end
      applyStimulus(w);
    end

    // Reset while a write sits in its wait states: outputs clear at once, memory keeps old value
    pushOp(0, BASE1 + 32'h20, 1'b1, 32'h0000_0005);
    pushOp(0, BASE1 + 32'h20, 1'b0, 32'd0);
    applyStimulus(1);
    @(negedge clk);
    driveBus(1, 1'b1, 2'b10, BASE1 + 32'h20, 1'b1);
    setWdata(1, 32'h0000_1234);
    @(negedge clk);
    readBus(1, r, p, d);
    checkOutput("preRstWait", 32'(r), 32'd0);
    checkOutput("preRstRdata", d, 32'h0000_0005);
    driveBus(1, 1'b0, 2'b00, 32'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    readBus(1, r, p, d);
    checkOutput("midRstReady", 32'(r), 32'd1);
    checkOutput("midRstResp", 32'(p), 32'd0);
    checkOutput("midRstRdata", d, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pushOp(0, BASE1 + 32'h20, 1'b0, 32'd0);
    applyStimulus(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
